dma_rd_engine: RTL and testbench

//  AXI read-side engine of the DMA master path. Accepts a word-copy read job (src, len) from the DMA core,

---
 rtl/dma_rd_engine.sv | 234 +++++++++++++++++++++++
 tb/tb_dma_rd_engine.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/dma_rd_engine.sv
// dma_rd_engine
//   AXI read-side engine of the DMA master path. A word-copy job (src, len)
//   is split into INCR bursts of at most MAX_BURST beats that never cross a
//   4KB page. Returned beats land in a first-word-fall-through FIFO that the
//   DMA write side drains through a valid/ready stream.
//
//   Optional feature macro: DMA_RD_PERF_EN
//     Adds output rd_stall_cycles[31:0]. It counts the cycles spent in the
//     address phase without an AR handshake and saturates at all-ones.
//
// Ports
//   clk, rst                 clock, async active-high reset
//   rd_start/rd_src/rd_len   job request (sampled only when idle)
//   rd_busy/rd_done/rd_err   job status; rd_done is a 1-cycle pulse
//   AR*                      AXI read address channel (master side)
//   R*                       AXI read data channel (master side)
//   out_data/valid/ready     FIFO head stream toward the write side
//   rd_stall_cycles          stall counter (DMA_RD_PERF_EN only)
module dma_rd_engine #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LEN_W      = 16,
    parameter int MAX_BURST  = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_start,
    input  logic [ADDR_W-1:0] rd_src,
    input  logic [LEN_W-1:0]  rd_len,
    output logic              rd_busy,
    output logic              rd_done,
    output logic              rd_err,
    output logic [ADDR_W-1:0] ARADDR,
    output logic [3:0]        ARLEN,
    output logic              ARVALID,
    input  logic              ARREADY,
    input  logic [DATA_W-1:0] RDATA,
    input  logic [1:0]        RRESP,
    input  logic              RLAST,
    input  logic              RVALID,
    output logic              RREADY,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready
`ifdef DMA_RD_PERF_EN
    ,
    output logic [31:0]       rd_stall_cycles
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int NB_W  = 5;   // holds 1..16 beats

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q;
    logic [LEN_W-1:0]   rem_q;
    logic [NB_W-1:0]    nb_q;       // beats of the burst in flight
    logic [NB_W-1:0]    beat_q;     // beats seen so far in that burst
    logic               err_q;

    logic [DATA_W-1:0]  mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   cnt_q;

    // ---------------------------------------------------------------
    // Burst sizing: min(remaining, MAX_BURST, words left in 4KB page)
    // ---------------------------------------------------------------
    logic [12:0]        pg_bytes;
    logic [10:0]        pg_words;
    logic [LEN_W-1:0]   n_full;
    logic [NB_W-1:0]    n_cur;
    logic [CNT_W-1:0]   free_ent;
    logic               credit_ok;

    assign pg_bytes = 13'h1000 - {1'b0, addr_q[11:0]};
    assign pg_words = pg_bytes[12:2];

    always_comb begin
        n_full = LEN_W'(MAX_BURST);
        if (rem_q < n_full)
            n_full = rem_q;
        if (LEN_W'(pg_words) < n_full)
            n_full = LEN_W'(pg_words);
    end
    assign n_cur = n_full[NB_W-1:0];

    // Only one burst is ever outstanding and nothing is pushed while in
    // ADDR, so free space can only grow while ARVALID waits: once raised it
    // stays up until the handshake.
    assign free_ent  = CNT_W'(FIFO_DEPTH) - cnt_q;
    assign credit_ok = 32'(free_ent) >= 32'(n_cur);

    // ---------------------------------------------------------------
    // Handshakes and beat classification
    // ---------------------------------------------------------------
    logic               start_acc, ar_hs, r_hs, push, pop, beat_err;
    logic [LEN_W-1:0]   rem_after;

    assign start_acc = (state_q == S_IDLE) && rd_start;
    assign ARVALID   = (state_q == S_ADDR) && credit_ok;
    assign ARADDR    = addr_q;
    assign ARLEN     = (state_q == S_ADDR) ? (n_cur[3:0] - 4'd1) : 4'd0;
    assign ar_hs     = ARVALID && ARREADY;
    assign RREADY    = (state_q == S_DATA);
    assign r_hs      = RREADY && RVALID;

    // Beats past an error, or beyond the granted count, are dropped so the
    // FIFO never exceeds the credit reserved at AR time.
    assign push      = r_hs && (RRESP == 2'b00) && !err_q && (beat_q < nb_q);
    assign beat_err  = r_hs && ((RRESP != 2'b00) || (beat_q >= nb_q) ||
                                (RLAST && ((beat_q + 5'd1) != nb_q)));
    assign rem_after = rem_q - LEN_W'(nb_q);

    assign pop       = out_valid && out_ready;
    assign out_valid = (cnt_q != '0);
    assign out_data  = mem[rd_ptr_q];

    assign rd_busy   = (state_q != S_IDLE);
    assign rd_done   = (state_q == S_DONE);
    assign rd_err    = err_q;

    // ---------------------------------------------------------------
    // FSM
    // ---------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (rd_start) state_d = (rd_len == '0) ? S_DONE : S_ADDR;
            S_ADDR: if (ar_hs)    state_d = S_DATA;
            S_DATA: begin
                if (r_hs && RLAST) begin
                    if (err_q || beat_err || (rem_after == '0))
                        state_d = S_DONE;
                    else
                        state_d = S_ADDR;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------------------------------------------------------
    // Job datapath
    // ---------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q <= '0;
            rem_q  <= '0;
            nb_q   <= '0;
            beat_q <= '0;
            err_q  <= 1'b0;
        end else begin
            if (start_acc) begin
                addr_q <= {rd_src[ADDR_W-1:2], 2'b00};
                rem_q  <= rd_len;
                err_q  <= 1'b0;
            end
            if (ar_hs) begin
                nb_q   <= n_cur;
                beat_q <= '0;
            end
            if (r_hs) begin
                if (beat_q < nb_q)
                    beat_q <= beat_q + 5'd1;
                if (beat_err)
                    err_q <= 1'b1;
                if (RLAST) begin
                    addr_q <= addr_q + ADDR_W'({nb_q, 2'b00});
                    rem_q  <= rem_after;
                end
            end
        end
    end

    // ---------------------------------------------------------------
    // FIFO (pointers wrap naturally, depth is a power of two)
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr_q] <= RDATA;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

`ifdef DMA_RD_PERF_EN
    // ---------------------------------------------------------------
    // Address-phase stall counter
    // ---------------------------------------------------------------
    logic [31:0] stall_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_q <= '0;
        else if (start_acc)
            stall_q <= '0;
        else if ((state_q == S_ADDR) && !ar_hs && (stall_q != '1))
            stall_q <= stall_q + 32'd1;
    end
    assign rd_stall_cycles = stall_q;
`endif

    logic unused_ok;
    assign unused_ok = ^{rd_src[1:0], pg_bytes[1:0], n_full[LEN_W-1:NB_W]};

endmodule

// File: tb/tb_dma_rd_engine.sv
// Directed bench for dma_rd_engine: the bench plays the AXI slave, drives
// jobs and the output consumer, and checks AR addresses/lengths, word order,
// error handling, credit-based AR throttling and async reset.
module tb_dma_rd_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rd_start = 1'b0;
    logic [31:0] rd_src = '0;
    logic [15:0] rd_len = '0;
    logic        rd_busy, rd_done, rd_err;
    logic [31:0] ARADDR;
    logic [3:0]  ARLEN;
    logic        ARVALID;
    logic        ARREADY = 1'b0;
    logic [31:0] RDATA = '0;
    logic [1:0]  RRESP = '0;
    logic        RLAST = 1'b0;
    logic        RVALID = 1'b0;
    logic        RREADY;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
`ifdef DMA_RD_PERF_EN
    logic [31:0] rd_stall_cycles;
`endif

    dma_rd_engine dut (
        .clk(clk), .rst(rst),
        .rd_start(rd_start), .rd_src(rd_src), .rd_len(rd_len),
        .rd_busy(rd_busy), .rd_done(rd_done), .rd_err(rd_err),
        .ARADDR(ARADDR), .ARLEN(ARLEN), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
`ifdef DMA_RD_PERF_EN
        , .rd_stall_cycles(rd_stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    int          n_chk  = 0;
    int          n_pass = 0;
    logic [31:0] words[$];
    int          done_cnt = 0;
    int          arv_cnt  = 0;

    // Inputs change at posedge+1, so negedge sees settled handshakes.
    always @(negedge clk) begin
        if (out_valid && out_ready) words.push_back(out_data);
        if (rd_done) done_cnt++;
        if (ARVALID) arv_cnt++;
    end

    function automatic logic [31:0] pat(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_job(input logic [31:0] src, input logic [15:0] len);
        rd_src = src; rd_len = len; rd_start = 1'b1;
        tick(1);
        rd_start = 1'b0;
    endtask

    // Wait for AR, check it, accept it and return the burst; beat err_beat
    // (0-based, -1 for none) carries SLVERR.
    task automatic serve(input string tag, input logic [31:0] ea, input logic [3:0] el,
                         input int err_beat);
        int t = 0;
        while (!ARVALID && t < 200) begin tick(1); t++; end
        chk({tag, "_arvalid"}, ARVALID, 1'b1);
        if (ARVALID) begin
            chk({tag, "_araddr"}, ARADDR, ea);
            chk({tag, "_arlen"}, ARLEN, el);
            ARREADY = 1'b1;
            tick(1);
            ARREADY = 1'b0;
            for (int b = 0; b <= int'(el); b++) begin
                RVALID = 1'b1;
                RDATA  = pat(ea + 32'(4 * b));
                RRESP  = (b == err_beat) ? 2'b10 : 2'b00;
                RLAST  = (b == int'(el));
                tick(1);
            end
            RVALID = 1'b0; RLAST = 1'b0; RRESP = 2'b00;
        end
    endtask

    task automatic check_words(input string tag, input logic [31:0] base, input int n);
        chk({tag, "_wcount"}, words.size(), n);
        for (int i = 0; i < n && i < words.size(); i++)
            chk({tag, "_word"}, words[i], pat(base + 32'(4 * i)));
    endtask

    initial begin
        int d0, a0;
        // ---- reset state
        #1;
        chk("rst_outs", {ARVALID, RREADY, rd_busy, rd_done, rd_err, out_valid}, 6'b0);
        chk("rst_ar", {ARADDR, ARLEN}, 36'h0);
        tick(2);
        rst = 1'b0;
        tick(1);

        // ---- 1: 20 words from 0x1000, three bursts
        out_ready = 1'b1; words.delete(); d0 = done_cnt;
        start_job(32'h1000, 16'd20);
        serve("t1b1", 32'h1000, 4'd7, -1);
        serve("t1b2", 32'h1020, 4'd7, -1);
        serve("t1b3", 32'h1040, 4'd3, -1);
        tick(10);
        check_words("t1", 32'h1000, 20);
        chk("t1_done", done_cnt - d0, 1);
        chk("t1_err", rd_err, 1'b0);
        chk("t1_busy", rd_busy, 1'b0);

        // ---- 2: 4KB split, low address bits ignored
        words.delete(); d0 = done_cnt;
        start_job(32'h0FFA, 16'd6);
        serve("t2b1", 32'h0FF8, 4'd1, -1);
        serve("t2b2", 32'h1000, 4'd3, -1);
        tick(10);
        check_words("t2", 32'h0FF8, 6);
        chk("t2_done", done_cnt - d0, 1);

        // ---- 3: zero-length job
        d0 = done_cnt; a0 = arv_cnt;
        start_job(32'h2000, 16'd0);
        chk("t3_done_hi", rd_done, 1'b1);
        tick(1);
        chk("t3_done_lo", {rd_done, rd_busy}, 2'b00);
        tick(3);
        chk("t3_no_ar", arv_cnt - a0, 0);
        chk("t3_done_cnt", done_cnt - d0, 1);

        // ---- 4: credit throttling with stalled consumer
        out_ready = 1'b0; words.delete(); d0 = done_cnt;
        start_job(32'h2000, 16'd32);
        serve("t4b1", 32'h2000, 4'd7, -1);
        serve("t4b2", 32'h2020, 4'd7, -1);
        tick(10);
        chk("t4_ar_withheld", ARVALID, 1'b0);
        chk("t4_full", {out_valid, out_data}, {1'b1, pat(32'h2000)});
        out_ready = 1'b1;
        tick(8);
        out_ready = 1'b0;
        chk("t4_ar_after_pops", {ARVALID, ARADDR}, {1'b1, 32'h2040});
        out_ready = 1'b1;
        serve("t4b3", 32'h2040, 4'd7, -1);
        serve("t4b4", 32'h2060, 4'd7, -1);
        tick(25);
        check_words("t4", 32'h2000, 32);
        chk("t4_done", done_cnt - d0, 1);

        // ---- 5: SLVERR on beat 3 of burst 1
        words.delete(); d0 = done_cnt;
        start_job(32'h3000, 16'd16);
        serve("t5b1", 32'h3000, 4'd7, 2);
        a0 = arv_cnt;
        tick(10);
        check_words("t5", 32'h3000, 2);
        chk("t5_no_ar2", arv_cnt - a0, 0);
        chk("t5_err", rd_err, 1'b1);
        chk("t5_done", done_cnt - d0, 1);
        chk("t5_idle", rd_busy, 1'b0);

        // ---- 6: async reset in DATA, then a normal job
        out_ready = 1'b0; words.delete();
        start_job(32'h4000, 16'd8);
        chk("t6_ar", ARVALID, 1'b1);
        ARREADY = 1'b1; tick(1); ARREADY = 1'b0;
        for (int b = 0; b < 2; b++) begin
            RVALID = 1'b1; RDATA = pat(32'h4000 + 32'(4 * b)); RLAST = 1'b0;
            tick(1);
        end
        RVALID = 1'b0;
        chk("t6_pre_rst", {RREADY, out_valid, rd_busy}, 3'b111);
        #2 rst = 1'b1;
        #1;
        chk("t6_async_rst", {ARVALID, RREADY, out_valid, rd_busy}, 4'b0);
        tick(1);
        rst = 1'b0;
        tick(1);
        out_ready = 1'b1; words.delete(); d0 = done_cnt;
        start_job(32'h5000, 16'd4);
        serve("t6b1", 32'h5000, 4'd3, -1);
        tick(10);
        check_words("t6", 32'h5000, 4);
        chk("t6_done", done_cnt - d0, 1);
        chk("t6_err", rd_err, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
